serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
// Bit-serial two's-complement subtractor computing D = A - B, LSB first, one bit per clock.
// Provides the inverse operation of the team's ripple full-adder datapath.
// Trades latency for area: a single 1-bit full-subtractor cell plus shift registers.
// Sits beside the combinational adder in the lab ALU and is driven by a start/done handshake.
//
// PARAMETERS
// WIDTH   8   operand/result width in bits; legal range WIDTH >= 2
//
// PORTS
// clk     in   1      single clock; all state changes on rising edge
// rst     in   1      synchronous, active-high reset
// start   in   1      request; sampled only in IDLE
// A       in   WIDTH  minuend; sampled on the cycle start is accepted
// B       in   WIDTH  subtrahend; sampled on the cycle start is accepted
// busy    out  1      high while the subtraction is in progress (SHIFT state)
// done    out  1      one-cycle pulse; D/Bout/V valid from this cycle onward
// D       out  WIDTH  difference A - B, modulo 2^WIDTH
// Bout    out  1      final borrow; 1 iff A < B (unsigned)
// V       out  1      signed overflow of A - B
//
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, done=0, D=0, Bout=0, V=0; borrow FF=0; bit counter=0.
// - rst has priority over every other input, including start in the same cycle.
// - FSM states: IDLE -> SHIFT -> DONE -> IDLE.
// - IDLE: if start=1 at an edge -> latch A and B into shift regs, latch A[WIDTH-1] and
//   B[WIDTH-1], clear borrow and counter, go to SHIFT; otherwise stay. D/Bout/V hold.
// - SHIFT: busy=1 for exactly WIDTH cycles. Each cycle:
//   - cell computes d = a0^b0^bin and bo = (~a0&b0) | (~(a0^b0)&bin).
//   - d shifts into the MSB of the result reg (right shift); operands shift right.
//   - borrow <= bo; counter++.
//   - After the WIDTH-th bit -> DONE.
// - DONE: for 1 cycle, done=1 and busy=0. D = result reg, Bout = borrow,
//   V = (Amsb != Bmsb) && (D[WIDTH-1] != Amsb). These are written on DONE entry.
//   Next state is IDLE.
// - Latency: start accepted at edge k -> busy=1 for cycles k+1..k+WIDTH -> done=1 in cycle k+WIDTH+1.
// - Throughput: one result per WIDTH+2 cycles with start held high.
// - start while busy or while done=1: ignored, with no queuing.
// - A/B changes after acceptance have no effect.
// - D/Bout/V hold their last result until the next DONE. They are not cleared by a new start.
// - Reset mid-operation: the next cycle is the reset state, with no done pulse. The partial result is discarded.
// - busy and done are never high in the same cycle.
//
// STRUCTURE
// - Shared include serial_sub_defs.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
//   The counter width is $clog2(WIDTH+1), computed locally.
// - Sub-module full_subtractor_cell: inputs a, b, bin; outputs d, bout. Gate-level, combinational.
// - Top level holds the FSM, operand/result shift regs, borrow FF, counter and output regs.
// - Every output is driven from a flop.
//
// TESTING
// Directed scenarios, with WIDTH=8 unless noted:
// 1. A=100, B=37, start pulse -> busy for 8 cycles; done in cycle 9 after acceptance.
//    Required result: D=8'd63, Bout=0, V=0.
// 2. A=8'd5, B=8'd9 -> D=8'hFC, Bout=1, V=0.
//    Also A=B=8'hA5 -> D=0, Bout=0, V=0.
// 3. Signed overflow cases:
//    - A=8'h80, B=8'h01 -> D=8'h7F, Bout=0, V=1.
//    - A=8'h7F, B=8'hFF -> D=8'h80, Bout=1, V=1.
// 4. Start 8'd50 - 8'd20, then pulse start with 8'd1 - 8'd1 at SHIFT cycle 3 and again in the DONE cycle.
//    Required: both pulses ignored; a single done; D=8'd30.
// 5. rst asserted at SHIFT cycle 4 -> next cycle busy=0, done=0, D=0, Bout=0, V=0, with no done pulse.
//    A following start of 8'd7 - 8'd3 must give D=8'd4.
// 6. start held high, operands changed after each done -> a result every 10 cycles, each correct.
//    busy and done never overlap.
//    Repeat scenario 1 at WIDTH=2 and WIDTH=16 with random operands against a reference model.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the signed-overflow rule applied to the finished difference.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A - B overflows when the operands differ in sign and the result's sign
    // differs from the minuend's sign.
    function automatic logic sub_overflow(input logic amsb, input logic bmsb, input logic dmsb);
        return (amsb != bmsb) && (dmsb != amsb);
    endfunction

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic axb_s;

    assign axb_s = a ^ b;
    assign d     = axb_s ^ bin;
    assign bout  = (~a & b) | (~axb_s & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor D = A - B, LSB first, one bit per
// clock, using a single full-subtractor cell and operand/result shift regs.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic               amsb_q,   amsb_d;
    logic               bmsb_q,   bmsb_d;
    logic               borrow_q, borrow_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   diff_q,   diff_d;
    logic               bout_q,   bout_d;
    logic               ovf_q,    ovf_d;

    logic               cell_d_s;
    logic               cell_bo_s;
    logic [WIDTH-1:0]   res_shift_s;
    logic               last_bit_s;

    full_subtractor_cell u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (cell_d_s),
        .bout (cell_bo_s)
    );

    // New difference bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
    assign res_shift_s = {cell_d_s, res_q[WIDTH-1:1]};
    assign last_bit_s  = (cnt_q == CNT_W'(WIDTH - 1));

    // State and datapath registers; reset wins over any other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            amsb_q   <= 1'b0;
            bmsb_q   <= 1'b0;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            amsb_q   <= amsb_d;
            bmsb_q   <= bmsb_d;
            borrow_q <= borrow_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic: accept only in IDLE, shift WIDTH bits, one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_bit_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next values: operand load, serial shift, and result capture on DONE entry.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        amsb_d   = amsb_q;
        bmsb_d   = bmsb_q;
        borrow_d = borrow_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d   = A;
                    b_sh_d   = B;
                    amsb_d   = A[WIDTH-1];
                    bmsb_d   = B[WIDTH-1];
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            ST_SHIFT: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d    = res_shift_s;
                borrow_d = cell_bo_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit_s) begin
                    diff_d = res_shift_s;
                    bout_d = cell_bo_s;
                    ovf_d  = sub_overflow(amsb_q, bmsb_q, cell_d_s);
                end else begin
                    diff_d = diff_q;
                end
            end
            ST_DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    // Status outputs follow the state being entered so they are flop-driven and aligned with it.
    always_comb begin
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = diff_q;
    assign Bout = bout_q;
    assign V    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 2 and 16, using a
// plain-arithmetic reference model of A - B.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8, start8, busy8, done8, bout8, v8;
    logic [7:0]  a8, b8, d8;
    logic        rst2, start2, busy2, done2, bout2, v2;
    logic [1:0]  a2, b2, d2;
    logic        rst16, start16, busy16, done16, bout16, v16;
    logic [15:0] a16, b16, d16;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .D(d8), .Bout(bout8), .V(v8)
    );
    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .A(a2), .B(b2),
        .busy(busy2), .done(done2), .D(d2), .Bout(bout2), .V(v2)
    );
    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .A(a16), .B(b16),
        .busy(busy16), .done(done16), .D(d16), .Bout(bout16), .V(v16)
    );

    // Reference: returns {V, Bout, D[15:0]} for a w-bit subtraction.
    function automatic logic [17:0] ref_model(input int w, input logic [15:0] a, input logic [15:0] b);
        longint m, half, ua, ub, sa, sb, sd, dv;
        logic [15:0] dd;
        logic bo, ov;
        m    = longint'(1) << w;
        half = m >> 1;
        ua   = longint'(a) & (m - 1);
        ub   = longint'(b) & (m - 1);
        dv   = (ua - ub) & (m - 1);
        dd   = dv[15:0];
        bo   = (ua < ub);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        sd   = sa - sb;
        ov   = (sd >= half) || (sd < -half);
        return {ov, bo, dd};
    endfunction

    // Observed {done, busy, V, Bout, D zero-extended to 16}.
    function automatic logic [19:0] obs(input int w);
        case (w)
            2:       return {done2, busy2, v2, bout2, 14'd0, d2};
            16:      return {done16, busy16, v16, bout16, d16};
            default: return {done8, busy8, v8, bout8, 8'd0, d8};
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b);
        case (w)
            2:       begin start2 = s;  a2 = a[1:0]; b2 = b[1:0]; end
            16:      begin start16 = s; a16 = a;     b16 = b;     end
            default: begin start8 = s;  a8 = a[7:0]; b8 = b[7:0]; end
        endcase
    endtask

    // One start pulse; checks busy every shift cycle, the done cycle, and the result.
    task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b);
        logic [17:0] exp;
        logic [19:0] o;
        @(negedge clk);
        drive(w, 1'b1, a, b);
        exp = ref_model(w, a, b);
        for (int c = 1; c <= w + 1; c++) begin
            @(negedge clk);
            o = obs(w);
            if (c == 1) drive(w, 1'b0, ~a, ~b);
            if (c <= w) begin
                checks++;
                if (o[19:18] !== 2'b01) begin
                    errors++;
                    $display("FAIL shift_status w=%0d cyc=%0d: got done,busy=%b required 01", w, c, o[19:18]);
                end
            end else begin
                checks++;
                if (o[19:18] !== 2'b10) begin
                    errors++;
                    $display("FAIL done_status w=%0d: got done,busy=%b required 10", w, o[19:18]);
                end
                checks++;
                if (o[17:0] !== exp) begin
                    errors++;
                    $display("FAIL result w=%0d A=%h B=%h: got V,Bout,D=%h required %h", w, a, b, o[17:0], exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst8 = 1'b1; rst2 = 1'b1; rst16 = 1'b1;
        drive(8, 1'b1, 16'hFF, 16'h01);
        drive(2, 1'b1, 16'h3, 16'h1);
        drive(16, 1'b1, 16'hFFFF, 16'h1);
        repeat (3) @(negedge clk);
        checks++;
        if (obs(8) !== 20'd0) begin errors++; $display("FAIL reset_w8: got %h required 0", obs(8)); end
        checks++;
        if (obs(2) !== 20'd0) begin errors++; $display("FAIL reset_w2: got %h required 0", obs(2)); end
        checks++;
        if (obs(16) !== 20'd0) begin errors++; $display("FAIL reset_w16: got %h required 0", obs(16)); end
        drive(8, 1'b0, 16'h0, 16'h0);
        drive(2, 1'b0, 16'h0, 16'h0);
        drive(16, 1'b0, 16'h0, 16'h0);
        rst8 = 1'b0; rst2 = 1'b0; rst16 = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0]  ta [5] = '{8'd100, 8'd5, 8'hA5, 8'h80, 8'h7F};
        logic [7:0]  tb [5] = '{8'd37,  8'd9, 8'hA5, 8'h01, 8'hFF};
        logic [9:0]  te [5] = '{{2'b00, 8'd63}, {2'b01, 8'hFC}, {2'b00, 8'h00},
                                {2'b10, 8'h7F}, {2'b11, 8'h80}};
        logic [19:0] o;
        for (int i = 0; i < 5; i++) begin
            run_op(8, {8'd0, ta[i]}, {8'd0, tb[i]});
            o = obs(8);
            checks++;
            if ({o[17:16], o[7:0]} !== te[i]) begin
                errors++;
                $display("FAIL directed_%0d: got V,Bout,D=%b,%b,%h required %h", i, o[17], o[16], o[7:0], te[i]);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [19:0] o;
        int dones = 0;
        @(negedge clk);
        drive(8, 1'b1, 16'd50, 16'd20);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            o = obs(8);
            if (o[19]) dones++;
            if (c > 9) begin
                checks++;
                if (o[18] !== 1'b0) begin errors++; $display("FAIL ignored_start_busy cyc=%0d: got busy=%b required 0", c, o[18]); end
            end
            case (c)
                1:       drive(8, 1'b0, 16'd50, 16'd20);
                3:       drive(8, 1'b1, 16'd1, 16'd1);
                4:       drive(8, 1'b0, 16'd1, 16'd1);
                9:       drive(8, 1'b1, 16'd1, 16'd1);
                10:      drive(8, 1'b0, 16'd1, 16'd1);
                default: ;
            endcase
        end
        checks++;
        if (dones != 1) begin errors++; $display("FAIL ignored_start_dones: got %0d required 1", dones); end
        o = obs(8);
        checks++;
        if ({o[17:16], o[7:0]} !== {2'b00, 8'd30}) begin
            errors++;
            $display("FAIL ignored_start_result: got V,Bout,D=%b,%b,%h required 0,0,1e", o[17], o[16], o[7:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] o;
        int seen = 0;
        @(negedge clk);
        drive(8, 1'b1, 16'd200, 16'd13);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) drive(8, 1'b0, 16'd200, 16'd13);
        end
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        o = obs(8);
        checks++;
        if (o !== 20'd0) begin errors++; $display("FAIL reset_mid: got %h required 0", o); end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            o = obs(8);
            if (o[19] || o[18]) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_quiet: got %0d active cycles required 0", seen); end
        run_op(8, 16'd7, 16'd3);
        o = obs(8);
        checks++;
        if (o[7:0] !== 8'd4) begin errors++; $display("FAIL after_reset_result: got D=%h required 04", o[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [19:0] o;
        logic [17:0] exp;
        int idx = 0;
        int last = 0;
        for (int i = 0; i < 4; i++) begin
            va[i] = 16'($urandom_range(0, 255));
            vb[i] = 16'($urandom_range(0, 255));
        end
        @(negedge clk);
        drive(8, 1'b1, va[0], vb[0]);
        for (int c = 1; c <= 60 && idx < 4; c++) begin
            @(negedge clk);
            o = obs(8);
            checks++;
            if (o[19] && o[18]) begin errors++; $display("FAIL b2b_overlap cyc=%0d: got busy=1 done=1 required not both", c); end
            if (o[19]) begin
                exp = ref_model(8, va[idx], vb[idx]);
                checks++;
                if (o[17:0] !== exp) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got %h required %h", idx, o[17:0], exp);
                end
                if (idx > 0) begin
                    checks++;
                    if (c - last != 10) begin errors++; $display("FAIL b2b_spacing_%0d: got %0d required 10", idx, c - last); end
                end
                last = c;
                idx++;
                if (idx < 4) drive(8, 1'b1, va[idx], vb[idx]);
                else drive(8, 1'b0, 16'd0, 16'd0);
            end
        end
        drive(8, 1'b0, 16'd0, 16'd0);
        checks++;
        if (idx != 4) begin errors++; $display("FAIL b2b_count: got %0d results required 4", idx); end
    endtask

    task automatic test_widths();
        for (int i = 0; i < 6; i++) run_op(2, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 6; i++) run_op(16, 16'($urandom), 16'($urandom));
        for (int i = 0; i < 6; i++) run_op(8, 16'($urandom), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_widths();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
